// File: rtl/l1_device_resp_adapter.sv
// Device-end responder: forwards interconnect requests to a simple peripheral and returns in-order responses.
// Latency: dev_req_o in the accept cycle; resp_valid_o one cycle after dev_rvalid_i (registered data FIFO).
// Backpressure: credit-based; req_ready_o drops once RespFifoDepth requests are in flight or awaiting pickup.
// Optional feature macro: DEV_ADAPTER_TIMEOUT_EN (response timeout with late-response drop).
module l1_device_resp_adapter #(
  parameter int DataWidth     = 32,
  parameter int AddrWidth     = 20,
  parameter int HostIdWidth   = 1,
  parameter int RespFifoDepth = 2,
  parameter int TimeoutCycles = 255,
  parameter logic [DataWidth-1:0] TimeoutData = DataWidth'(32'hBADC0DE5)
) (
  input  logic                   clk_sys_in,
  input  logic                   rst_sys_in,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [HostIdWidth-1:0] req_ini_addr_i,
  input  logic [AddrWidth-1:0]   req_tgt_addr_i,
  input  logic                   req_wen_i,
  input  logic [DataWidth-1:0]   req_wdata_i,
  input  logic [DataWidth/8-1:0] req_be_i,
  output logic                   resp_valid_o,
  input  logic                   resp_ready_i,
  output logic [HostIdWidth-1:0] resp_ini_addr_o,
  output logic [DataWidth-1:0]   resp_rdata_o,
  output logic                   dev_req_o,
  output logic                   dev_we_o,
  output logic [DataWidth/8-1:0] dev_be_o,
  output logic [DataWidth-1:0]   dev_wdata_o,
  output logic [31:0]            dev_addr_o,
  input  logic                   dev_rvalid_i,
  input  logic [DataWidth-1:0]   dev_rdata_i,
  output logic                   err_o,
  output logic                   timeout_o
);

  localparam int PtrW = (RespFifoDepth > 1) ? $clog2(RespFifoDepth) : 1;
  localparam int CntW = $clog2(RespFifoDepth + 1);
  localparam logic [CntW-1:0] DepthC = CntW'(RespFifoDepth);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(RespFifoDepth - 1);

  // ID FIFO holds one entry per accepted request until its response is picked up;
  // the data FIFO holds responses returned by the peripheral (or synthesised on timeout).
  logic [HostIdWidth-1:0] r_id_mem [RespFifoDepth];
  logic [DataWidth-1:0]   r_dat_mem[RespFifoDepth];
  logic [PtrW-1:0]        r_id_wptr, r_id_rptr, r_dat_wptr, r_dat_rptr;
  logic [CntW-1:0]        r_in_flight, r_resp_cnt;
  logic                   r_err;

  logic [CntW-1:0]        w_credits;
  logic                   w_accept, w_pop, w_push, w_dev_take, w_err_set;
  logic                   w_drop, w_tmo_fire;
  logic [DataWidth-1:0]   w_push_dat;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  assign w_credits    = DepthC - (r_in_flight + r_resp_cnt);
  assign req_ready_o  = (w_credits != '0);
  assign w_accept     = req_valid_i & req_ready_o;

  assign dev_req_o    = w_accept;
  assign dev_we_o     = req_wen_i;
  assign dev_be_o     = req_be_i;
  assign dev_wdata_o  = req_wdata_i;
  assign dev_addr_o   = 32'(req_tgt_addr_i);

  assign resp_valid_o    = (r_resp_cnt != '0);
  assign resp_rdata_o    = r_dat_mem[r_dat_rptr];
  assign resp_ini_addr_o = r_id_mem[r_id_rptr];
  assign w_pop           = resp_valid_o & resp_ready_i;

  // A peripheral response is either owed to a timed-out request (dropped), unsolicited (error),
  // or the next in-order response (queued).
  assign w_dev_take = dev_rvalid_i & ~w_drop & (r_in_flight != '0);
  assign w_err_set  = dev_rvalid_i & ~w_drop & (r_in_flight == '0);
  assign w_push     = w_dev_take | w_tmo_fire;
  assign w_push_dat = w_tmo_fire ? TimeoutData : dev_rdata_i;
  assign err_o      = r_err;

`ifdef DEV_ADAPTER_TIMEOUT_EN
  logic [15:0] r_timer;
  logic [15:0] r_drop_cnt;
  logic        r_timeout;

  assign w_drop     = dev_rvalid_i & (r_drop_cnt != 16'd0);
  // dev_rvalid_i in the same cycle as expiry takes priority, so no timeout is raised then.
  assign w_tmo_fire = (r_in_flight != '0) & ~dev_rvalid_i & (r_timer == 16'(TimeoutCycles));
  assign timeout_o  = r_timeout;

  // Response timer, outstanding-drop count and sticky timeout flag.
  always_ff @(posedge clk_sys_in or negedge rst_sys_in) begin
    if (!rst_sys_in) begin
      r_timer    <= 16'd0;
      r_drop_cnt <= 16'd0;
      r_timeout  <= 1'b0;
    end else begin
      if ((r_in_flight == '0) || dev_rvalid_i || w_tmo_fire) r_timer <= 16'd0;
      else                                                    r_timer <= r_timer + 16'd1;
      if (w_tmo_fire)  r_drop_cnt <= r_drop_cnt + 16'd1;
      else if (w_drop) r_drop_cnt <= r_drop_cnt - 16'd1;
      if (w_tmo_fire)  r_timeout <= 1'b1;
    end
  end
`else
  assign w_drop     = 1'b0;
  assign w_tmo_fire = 1'b0;
  assign timeout_o  = 1'b0;
`endif

  // FIFO storage, pointers, occupancy counters and sticky error flag.
  always_ff @(posedge clk_sys_in or negedge rst_sys_in) begin
    if (!rst_sys_in) begin
      for (int i = 0; i < RespFifoDepth; i++) begin
        r_id_mem[i]  <= '0;
        r_dat_mem[i] <= '0;
      end
      r_id_wptr   <= '0;
      r_id_rptr   <= '0;
      r_dat_wptr  <= '0;
      r_dat_rptr  <= '0;
      r_in_flight <= '0;
      r_resp_cnt  <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_id_mem[r_id_wptr] <= req_ini_addr_i;
        r_id_wptr           <= ptr_inc(r_id_wptr);
      end
      if (w_push) begin
        r_dat_mem[r_dat_wptr] <= w_push_dat;
        r_dat_wptr            <= ptr_inc(r_dat_wptr);
      end
      if (w_pop) begin
        r_id_rptr  <= ptr_inc(r_id_rptr);
        r_dat_rptr <= ptr_inc(r_dat_rptr);
      end
      r_in_flight <= r_in_flight + CntW'(w_accept) - CntW'(w_push);
      r_resp_cnt  <= r_resp_cnt + CntW'(w_push) - CntW'(w_pop);
      if (w_err_set) r_err <= 1'b1;
    end
  end

endmodule
